rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 145 ++++++++++++++
 tb/tb_rst_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// ============================================================================
//  Module   : rst_sequencer
//  Purpose  : Reset synchronizer plus timed, staggered per-domain reset release
//             with software-reset re-sequencing. Optional macro
//             RST_SEQUENCER_SW_COUNT_EN enables the saturating sw_rst_count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_sequencer #(
   parameter int NR_OF_DOMAINS_P = 4,
   parameter int SYNC_STAGES_P   = 2,
   parameter int HOLD_CYCLES_P   = 16,
   parameter int STEP_CYCLES_P   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       rst_sync_n,
   output logic [NR_OF_DOMAINS_P-1:0] domain_rst_n,
   output logic                       seq_done,
   input  logic                       sw_rst_req,
   output logic                       sw_rst_ack,
   output logic [7:0]                 sw_rst_count
);

   localparam int c_CNT_MAX = (HOLD_CYCLES_P > STEP_CYCLES_P) ? HOLD_CYCLES_P : STEP_CYCLES_P;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   localparam logic [c_CNT_W-1:0]         c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES_P - 1);
   localparam logic [c_CNT_W-1:0]         c_STEP_LAST = c_CNT_W'(STEP_CYCLES_P - 1);
   localparam logic [c_CNT_W-1:0]         c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [NR_OF_DOMAINS_P-1:0] c_DOM_LSB   = NR_OF_DOMAINS_P'(1);

   typedef enum logic [1:0] {
      SYNC_S    = 2'd0,
      ASSERT_S  = 2'd1,
      RELEASE_S = 2'd2,
      RUN_S     = 2'd3
   } state_t;

   logic [SYNC_STAGES_P-1:0]   r_sync;
   state_t                     r_state;
   logic [c_CNT_W-1:0]         r_cnt;
   logic [NR_OF_DOMAINS_P-1:0] r_dom;
   logic                       r_done;
   logic                       r_ack;
   logic [NR_OF_DOMAINS_P-1:0] w_dom_next;

   // Classic async-assert / sync-deassert chain; a constant 1 shifts in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES_P-2:0], 1'b1};
      end
   end

   assign rst_sync_n = r_sync[SYNC_STAGES_P-1];

   // Released domains form a thermometer code growing from bit 0, so the
   // next release is a shift-in of one; the top bit set marks the last step.
   assign w_dom_next = (r_dom << 1) | c_DOM_LSB;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SYNC_S;
         r_cnt   <= '0;
         r_dom   <= '0;
         r_done  <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            SYNC_S: begin
               if (rst_sync_n) begin
                  r_state <= ASSERT_S;
                  r_cnt   <= '0;
               end
            end
            ASSERT_S: begin
               if (r_cnt == c_HOLD_LAST) begin
                  r_cnt <= '0;
                  r_dom <= w_dom_next;
                  if (w_dom_next[NR_OF_DOMAINS_P-1]) begin
                     r_state <= RUN_S;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RELEASE_S;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            RELEASE_S: begin
               if (r_cnt == c_STEP_LAST) begin
                  r_cnt <= '0;
                  r_dom <= w_dom_next;
                  if (w_dom_next[NR_OF_DOMAINS_P-1]) begin
                     r_state <= RUN_S;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            RUN_S: begin
               if (sw_rst_req) begin
                  r_ack   <= 1'b1;
                  r_dom   <= '0;
                  r_done  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ASSERT_S;
               end
            end
            default: begin
               r_state <= SYNC_S;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign domain_rst_n = r_dom;
   assign seq_done     = r_done;
   assign sw_rst_ack   = r_ack;

`ifdef RST_SEQUENCER_SW_COUNT_EN
   logic [7:0] r_sw_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_cnt <= 8'h00;
      end else if (r_ack && (r_sw_cnt != 8'hFF)) begin
         r_sw_cnt <= r_sw_cnt + 8'd1;
      end
   end

   assign sw_rst_count = r_sw_cnt;
`else
   assign sw_rst_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_sequencer.sv
// ============================================================================
//  Module   : tb_rst_sequencer
//  Purpose  : Directed self-checking bench for rst_sequencer (N=4 and N=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_sequencer;

   logic       clk         = 1'b0;
   logic       clk_en      = 1'b1;
   logic       rst_n       = 1'b0;
   logic       sw_rst_req  = 1'b0;
   logic       sw_rst_req1 = 1'b0;

   logic       rst_sync_n, seq_done, sw_rst_ack;
   logic [3:0] dom;
   logic [7:0] sw_cnt;
   logic       rst_sync_n1, seq_done1, sw_rst_ack1;
   logic [0:0] dom1;
   logic [7:0] sw_cnt1;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef RST_SEQUENCER_SW_COUNT_EN
   localparam bit c_CNT_EN = 1'b1;
`else
   localparam bit c_CNT_EN = 1'b0;
`endif

   rst_sequencer u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rst_sync_n   (rst_sync_n),
      .domain_rst_n (dom),
      .seq_done     (seq_done),
      .sw_rst_req   (sw_rst_req),
      .sw_rst_ack   (sw_rst_ack),
      .sw_rst_count (sw_cnt)
   );

   rst_sequencer #(.NR_OF_DOMAINS_P(1)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .rst_sync_n   (rst_sync_n1),
      .domain_rst_n (dom1),
      .seq_done     (seq_done1),
      .sw_rst_req   (sw_rst_req1),
      .sw_rst_ack   (sw_rst_ack1),
      .sw_rst_count (sw_cnt1)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Domain k releases 16 + 8k edges after the ASSERT_S entry edge.
   function automatic logic [3:0] exp_dom(input int since);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = (since >= 16 + 8 * k);
      return r;
   endfunction

   function automatic logic [7:0] exp_cnt(input int n);
      if (!c_CNT_EN) return 8'd0;
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_sync"},  32'(rst_sync_n),  32'd0);
      check({tag, "_dom"},   32'(dom),         32'd0);
      check({tag, "_done"},  32'(seq_done),    32'd0);
      check({tag, "_ack"},   32'(sw_rst_ack),  32'd0);
      check({tag, "_cnt"},   32'(sw_cnt),      32'd0);
      check({tag, "_sync1"}, 32'(rst_sync_n1), 32'd0);
      check({tag, "_dom1"},  32'(dom1),        32'd0);
      check({tag, "_done1"}, 32'(seq_done1),   32'd0);
   endtask

   // Called with rst_n just raised and clk low: next posedge is edge 1.
   task automatic power_on_seq();
      int since;
      for (int e = 1; e <= 45; e++) begin
         step();
         since = (e >= 3) ? e - 3 : -1;
         check("po_sync",  32'(rst_sync_n),  32'(e >= 2));
         check("po_dom",   32'(dom),         32'(exp_dom(since)));
         check("po_done",  32'(seq_done),    32'(since >= 40));
         check("po_ack",   32'(sw_rst_ack),  32'd0);
         check("po_sync1", 32'(rst_sync_n1), 32'(e >= 2));
         check("po_dom1",  32'(dom1),        32'(since >= 16));
         check("po_done1", 32'(seq_done1),   32'(since >= 16));
      end
   endtask

   task automatic sw_seq(input int from, input int to, input int req_at);
      for (int s = from; s <= to; s++) begin
         step();
         check("sw_sync", 32'(rst_sync_n), 32'd1);
         check("sw_dom",  32'(dom),        32'(exp_dom(s)));
         check("sw_done", 32'(seq_done),   32'(s >= 40));
         check("sw_ack",  32'(sw_rst_ack), 32'd0);
         if (s == req_at) sw_rst_req = 1'b1;
      end
   endtask

   task automatic sw_accept(input string tag);
      step();
      check({tag, "_ack"},  32'(sw_rst_ack), 32'd1);
      check({tag, "_dom"},  32'(dom),        32'd0);
      check({tag, "_done"}, 32'(seq_done),   32'd0);
      check({tag, "_sync"}, 32'(rst_sync_n), 32'd1);
      sw_rst_req = 1'b0;
   endtask

   initial begin
      int timeouts;
      bit got;

      repeat (3) step();
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      power_on_seq();

      // Software reset from RUN_S.
      sw_rst_req = 1'b1;
      sw_accept("swr");
      sw_seq(1, 41, -1);
      check("swr_cnt", 32'(sw_cnt), 32'(exp_cnt(1)));

      // Request raised mid-RELEASE_S is held until RUN_S entry.
      sw_rst_req = 1'b1;
      sw_accept("swr2");
      sw_seq(1, 40, 20);
      sw_accept("rel_req");
      sw_seq(1, 45, -1);
      check("rel_cnt", 32'(sw_cnt), 32'(exp_cnt(3)));

      // Async reset mid-RELEASE_S with the clock stopped.
      sw_rst_req = 1'b1;
      sw_accept("swr4");
      sw_seq(1, 25, -1);
      check("pre_rst_cnt", 32'(sw_cnt), 32'(exp_cnt(4)));
      @(negedge clk);
      #1 clk_en = 1'b0;
      #10 rst_n = 1'b0;
      #1 check_all_zero("async");
      #10 check_all_zero("async_hold");
      rst_n = 1'b1;
      #2 clk_en = 1'b1;
      power_on_seq();

      // Saturation of the accepted-request counter.
      timeouts = 0;
      for (int i = 0; i < 300; i++) begin
         sw_rst_req = 1'b1;
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (sw_rst_ack) got = 1'b1;
         end
         sw_rst_req = 1'b0;
         if (!got) timeouts++;
         got = 1'b0;
         for (int t = 0; t < 60 && !got; t++) begin
            step();
            if (seq_done) got = 1'b1;
         end
         if (!got) timeouts++;
      end
      check("sat_timeouts", 32'(timeouts), 32'd0);
      step();
      check("sat_cnt",  32'(sw_cnt),  32'(exp_cnt(300)));
      check("sat_cnt1", 32'(sw_cnt1), 32'd0);
      check("sat_sync", 32'(rst_sync_n), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
